reg_fifo: RTL
=============

REG_FIFO -- requirements
Module: reg_fifo

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (WIDTH >= 1).
REQ-002 Parameter DEPTH, default 4, number of storage words; a power of two, DEPTH >= 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in  input  WIDTH  write data, captured when a push is accepted.
REQ-006 push  input  1  write request.
REQ-007 pop  input  1  read request; removes the head word.
REQ-008 out  output  WIDTH  head word (oldest stored), show-ahead.
REQ-009 empty  output  1  high when count == 0.
REQ-010 full  output  1  high when count == DEPTH.
REQ-011 count  output  $clog2(DEPTH+1)  number of words stored.
REQ-012 err  output  1  sticky flag for a rejected push or a rejected pop.

Function
REQ-013 Accepted push = push & (~full | pop); an accepted push writes in to slot wr_ptr at the edge.
REQ-014 Accepted pop = pop & ~empty; an accepted pop advances rd_ptr at the edge.
REQ-015 wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no extra logic.
REQ-016 count rises by 1 on a push-only edge, falls by 1 on a pop-only edge, and holds when both or neither are accepted.
REQ-017 Push and pop together while full: both are accepted, count stays DEPTH, and the new word lands in the slot just freed.
REQ-018 Push and pop together while empty: the pop is rejected, the push is accepted, count becomes 1, and err is set.
REQ-019 Push while full without pop: the push is rejected, storage, pointers and count are unchanged, and err is set.
REQ-020 Pop while empty: rejected, with no state change except err being set.
REQ-021 out is combinational from storage[rd_ptr] when ~empty, and 0 when empty; a pushed word appears on out the cycle after the push edge (latency 1).
REQ-022 empty, full and count are derived from registered state only; they have no combinational path from push or pop.
REQ-023 Storage words not addressed by an accepted push hold their value, using load-gated hold, not clock gating.
REQ-024 err stays at 1 once set, until reset.

Reset
REQ-025 While reset is high at an edge: wr_ptr = 0, rd_ptr = 0, count = 0, err = 0; push and pop are ignored that cycle.
REQ-026 After a reset edge: empty = 1, full = 0, count = 0, out = 0, err = 0.
REQ-027 Storage contents are not cleared by reset; they are unobservable because out is 0 when empty.
REQ-028 Reset asserted mid-operation (FIFO partly full, push and pop active) returns the block to the REQ-026 state at that edge, and all stored words are lost.

Structure
REQ-029 No shared package; WIDTH and DEPTH are module parameters, and the pointer and count widths are localparams derived from them.
REQ-030 One sub-module, reg_word: a WIDTH-bit register with load that holds its value when load = 0. reg_fifo instantiates DEPTH copies, with load = accepted push & (wr_ptr == index).
REQ-031 All sequential state is edge-triggered on clk; the design contains no latches and no asynchronous reset.

Verification (WIDTH=16, DEPTH=4)
REQ-032 Reset then idle -> empty=1, full=0, count=0, out=0x0000, err=0.
REQ-033 Push 0x1111, 0x2222, 0x3333, 0x4444 -> full=1, count=4, out=0x1111; then 4 pops -> out steps through 0x2222, 0x3333, 0x4444, then 0, with empty=1.
REQ-034 Fill to full, then push 0x5555 without pop -> count=4, err=1; draining yields 0x1111..0x4444 only.
REQ-035 Fill to full, then push 0xAAAA with pop in the same cycle -> count=4, out=0x2222; after 3 more pops, out=0xAAAA.
REQ-036 Perform 6 push/pop pairs on a one-word-occupied FIFO so the pointers wrap -> data order is preserved, count=1 throughout, err=0.
REQ-037 Hold 3 words, then assert reset with push=1 -> next cycle count=0, empty=1, out=0, err=0; a subsequent push of 0x0BEE shows out=0x0BEE.

Source files
------------

// File: rtl/reg_word.sv
// Single storage word for reg_fifo: a plain register with a load enable.
// When load is low the word keeps its value; no clock gating, no reset.
module reg_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_fifo.sv
// Register-based show-ahead FIFO built from DEPTH reg_word instances.
// Rejected pushes and pops raise a sticky err flag that only reset clears.
module reg_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in,
    input  logic                       push,
    input  logic                       pop,
    output logic [WIDTH-1:0]           out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] words [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    // Popping a full FIFO frees the slot the new word lands in.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign out     = empty ? '0 : words[rd_ptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        reg_word #(.WIDTH(WIDTH)) u_word (
            .clk  (clk),
            .load (push_ok && (wr_ptr == PTR_W'(i))),
            .d    (in),
            .q    (words[i])
        );
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
            if ((push && !push_ok) || (pop && !pop_ok)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
